// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared framebuffer geometry, pixel types, fill FSM states and
//               the rectangle clipping helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;

    typedef logic [9:0]  fb_coord_t;
    typedef logic [23:0] rgb888_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    // Exclusive end coordinate of a span, clipped to the framebuffer edge.
    // The sum is widened to 11 bits so origin+length never wraps.
    function automatic logic [10:0] clip_end(input fb_coord_t  org,
                                             input fb_coord_t  len,
                                             input logic [10:0] lim);
        logic [10:0] sum;
        sum = {1'b0, org} + {1'b0, len};
        return (sum > lim) ? lim : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fb_addr_gen
// Description : Row-major pixel address walker for a clipped rectangle. Holds
//               the x/y counters and the row base; advances by increment only.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_addr_gen #(
    parameter int FB_WIDTH   = 320,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [9:0]            x0,
    input  logic [9:0]            y0,
    input  logic [10:0]           x_end,
    input  logic [10:0]           y_end,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  last
);
    import fb_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] c_row_step = ADDR_WIDTH'(FB_WIDTH);

    logic [10:0]           r_x;
    logic [10:0]           r_y;
    fb_coord_t             r_x0;
    logic [10:0]           r_x_end;
    logic [10:0]           r_y_end;
    logic [ADDR_WIDTH-1:0] r_row_base;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic                  w_row_end;
    logic [ADDR_WIDTH-1:0] w_load_base;
    logic [ADDR_WIDTH-1:0] w_next_base;

    // Constant multiply happens only once per command, at load time.
    assign w_load_base = ADDR_WIDTH'(y0) * c_row_step;
    assign w_next_base = r_row_base + c_row_step;
    assign w_row_end   = ((r_x + 11'd1) == r_x_end);
    assign last        = w_row_end && ((r_y + 11'd1) == r_y_end);
    assign wr_addr     = r_addr;

    // Counter walk: step right within a row, wrap to x0 on the next row.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_x0       <= '0;
            r_x_end    <= '0;
            r_y_end    <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
        end else if (load) begin
            r_x        <= {1'b0, x0};
            r_y        <= {1'b0, y0};
            r_x0       <= x0;
            r_x_end    <= x_end;
            r_y_end    <= y_end;
            r_row_base <= w_load_base;
            r_addr     <= w_load_base + ADDR_WIDTH'(x0);
        end else if (advance) begin
            if (w_row_end) begin
                r_x        <= {1'b0, r_x0};
                r_y        <= r_y + 11'd1;
                r_row_base <= w_next_base;
                r_addr     <= w_next_base + ADDR_WIDTH'(r_x0);
            end else begin
                r_x    <= r_x + 11'd1;
                r_addr <= r_addr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_rect_fill.sv
`default_nettype none
// ============================================================================
// Module      : fb_rect_fill
// Description : Rectangle fill engine. Latches a clipped rectangle command and
//               streams one framebuffer word write per pixel over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_rect_fill #(
    parameter int FB_WIDTH   = fb_pkg::FB_WIDTH,
    parameter int FB_HEIGHT  = fb_pkg::FB_HEIGHT,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [9:0]            x0,
    input  logic [9:0]            y0,
    input  logic [9:0]            width,
    input  logic [9:0]            height,
    input  logic [23:0]           color,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);
    import fb_pkg::*;

    localparam logic [10:0] c_fb_width_11  = 11'(FB_WIDTH);
    localparam logic [10:0] c_fb_height_11 = 11'(FB_HEIGHT);

    fill_state_t           r_state;
    fill_state_t           w_state_nxt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_wr_valid;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_err_nxt;
    logic                  w_valid_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_load;
    logic                  w_advance;

    rgb888_t               w_color;
    logic [10:0]           w_x_end;
    logic [10:0]           w_y_end;
    logic                  w_invalid;
    logic                  w_empty;
    logic                  w_last;

    assign w_color   = color;
    assign w_x_end   = clip_end(x0, width, c_fb_width_11);
    assign w_y_end   = clip_end(y0, height, c_fb_height_11);
    assign w_invalid = ({1'b0, x0} >= c_fb_width_11) || ({1'b0, y0} >= c_fb_height_11);
    assign w_empty   = (width == '0) || (height == '0);

    fb_addr_gen #(
        .FB_WIDTH   (FB_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (w_load),
        .advance (w_advance),
        .x0      (x0),
        .y0      (y0),
        .x_end   (w_x_end),
        .y_end   (w_y_end),
        .wr_addr (wr_addr),
        .last    (w_last)
    );

    // Next-state and next-output decode; all outputs are registered below.
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_valid_nxt = r_wr_valid;
        w_data_nxt  = r_wr_data;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_busy_nxt = 1'b1;
                    if (w_invalid || w_empty) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = w_invalid;
                    end else begin
                        w_state_nxt = FILL;
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = DATA_WIDTH'(w_color);
                        w_load      = 1'b1;
                    end
                end
            end
            FILL: begin
                if (r_wr_valid && wr_ready) begin
                    w_advance = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_wr_valid <= w_valid_nxt;
            r_wr_data  <= w_data_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign wr_valid = r_wr_valid;
    assign wr_data  = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_fb_rect_fill.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_rect_fill
// Description : Self-checking bench for fb_rect_fill: command table with a
//               write scoreboard, plus busy-start and mid-fill reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_rect_fill;

    typedef struct {
        int          x0;
        int          y0;
        int          w;
        int          h;
        logic [23:0] color;
        int          rdy;       // 0: ready always high, 1: 1,0,0,1 pattern
        int          exp_err;
        int          exp_n;
        int          exp_first;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [9:0]  x0, y0, width, height;
    logic [23:0] color;
    logic        busy, done, err, wr_valid, wr_ready;
    logic [31:0] wr_addr, wr_data;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    wr_t sb[$];
    int  hs_cnt = 0;
    int  last_hs_cyc = -1;
    int  first_valid_cyc = -1;
    logic [31:0] first_hs_addr = '0;
    int  rdy_mode = 0;
    int  rdy_idx  = 0;

    vec_t vt[12];

    fb_rect_fill dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .width    (width),
        .height   (height),
        .color    (color),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Ready driver
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) wr_ready = 1'b1;
            else begin
                wr_ready = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
                rdy_idx++;
            end
        end
    end

    // Write monitor / scoreboard
    initial begin
        logic        stall_pend;
        logic [31:0] st_addr, st_data;
        wr_t         e;
        stall_pend = 1'b0;
        st_addr = '0;
        st_data = '0;
        forever begin
            @(negedge clk);
            if (n_rst) stall_pend = 1'b0;
            else begin
                if (stall_pend) begin
                    chk("stall_valid", 32'(wr_valid), 32'd1);
                    chk("stall_addr", wr_addr, st_addr);
                    chk("stall_data", wr_data, st_data);
                end
                stall_pend = 1'b0;
                if (wr_valid) begin
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (wr_ready) begin
                        if (sb.size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL unexpected_write: addr %0d data %0h, none expected", wr_addr, wr_data);
                        end else begin
                            e = sb.pop_front();
                            chk("wr_addr", wr_addr, e.a);
                            chk("wr_data", wr_data, e.d);
                        end
                        if (hs_cnt == 0) first_hs_addr = wr_addr;
                        hs_cnt++;
                        last_hs_cyc = cyc;
                    end else begin
                        stall_pend = 1'b1;
                        st_addr = wr_addr;
                        st_data = wr_data;
                    end
                end
            end
        end
    end

    // Reference model: every clipped pixel in row-major order.
    task automatic push_model(input vec_t v);
        int xe, ye;
        wr_t e;
        xe = (v.x0 + v.w > 320) ? 320 : v.x0 + v.w;
        ye = (v.y0 + v.h > 240) ? 240 : v.y0 + v.h;
        if (v.x0 < 320 && v.y0 < 240)
            for (int y = v.y0; y < ye; y++)
                for (int x = v.x0; x < xe; x++) begin
                    e.a = 32'(y * 320 + x);
                    e.d = {8'h00, v.color};
                    sb.push_back(e);
                end
    endtask

    task automatic issue(input vec_t v, output int st);
        rdy_mode = v.rdy;
        rdy_idx  = 0;
        @(posedge clk);
        #1;
        x0 = 10'(v.x0); y0 = 10'(v.y0); width = 10'(v.w); height = 10'(v.h);
        color = v.color;
        start = 1'b1;
        st = cyc;
        hs_cnt = 0;
        first_valid_cyc = -1;
        last_hs_cyc = -1;
        push_model(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        // scramble inputs after latch; the DUT must ignore them
        x0 = 10'h155; y0 = 10'h0AA; width = 10'h3FF; height = 10'h3FF;
        color = 24'h5A5A5A;
    endtask

    task automatic run_cmd(input vec_t v, input bit busy_start);
        int  st, dc, extra;
        bit  got;
        issue(v, st);
        got = 1'b0;
        dc = -1;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (busy_start && i == 2) begin
                start = 1'b1; color = 24'h00FF00;
                x0 = 10'd0; y0 = 10'd0; width = 10'd5; height = 10'd5;
            end
            if (busy_start && i == 3) start = 1'b0;
            if (done) begin got = 1'b1; dc = cyc; end
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout: done not seen within 1000 cycles, expected a pulse");
        end else begin
            chk("err", 32'(err), 32'(v.exp_err));
            chk("busy_at_done", 32'(busy), 32'd1);
            chk("n_writes", 32'(hs_cnt), 32'(v.exp_n));
            chk("sb_drained", 32'(sb.size()), 32'd0);
            if (v.exp_n == 0) begin
                chk("done_lat_empty", 32'(dc - st), 32'd1);
                chk("no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
            end else begin
                chk("done_lat", 32'(dc - last_hs_cyc), 32'd1);
                chk("first_valid_lat", 32'(first_valid_cyc - st), 32'd1);
                chk("first_addr", first_hs_addr, 32'(v.exp_first));
            end
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("busy_idle", 32'(busy), 32'd0);
        end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("extra_done", 32'(extra), 32'd0);
        sb.delete();
    endtask

    task automatic reset_mid_fill();
        vec_t v;
        int   st;
        v = '{x0:5, y0:5, w:4, h:4, color:24'h0000FF, rdy:0, exp_err:0, exp_n:16, exp_first:1605};
        issue(v, st);
        for (int i = 0; i < 100 && hs_cnt < 2; i++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_hs_reached", 32'(hs_cnt), 32'd2);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        hs_cnt = 0;
        repeat (20) @(negedge clk);
        chk("rst_no_writes", 32'(hs_cnt), 32'd0);
        chk("rst_stays_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t vb;
        vt[0]  = '{x0:10,   y0:2,    w:3,    h:2,    color:24'hFF0000, rdy:0, exp_err:0, exp_n:6,  exp_first:650};
        vt[1]  = '{x0:10,   y0:2,    w:3,    h:2,    color:24'hFF0000, rdy:1, exp_err:0, exp_n:6,  exp_first:650};
        vt[2]  = '{x0:318,  y0:239,  w:5,    h:5,    color:24'h00ABCD, rdy:0, exp_err:0, exp_n:2,  exp_first:76798};
        vt[3]  = '{x0:10,   y0:2,    w:0,    h:4,    color:24'h111111, rdy:0, exp_err:0, exp_n:0,  exp_first:0};
        vt[4]  = '{x0:320,  y0:2,    w:3,    h:3,    color:24'h222222, rdy:0, exp_err:1, exp_n:0,  exp_first:0};
        vt[5]  = '{x0:5,    y0:240,  w:2,    h:2,    color:24'h333333, rdy:0, exp_err:1, exp_n:0,  exp_first:0};
        vt[6]  = '{x0:7,    y0:7,    w:4,    h:0,    color:24'h444444, rdy:0, exp_err:0, exp_n:0,  exp_first:0};
        vt[7]  = '{x0:0,    y0:0,    w:1,    h:1,    color:24'hABCDEF, rdy:1, exp_err:0, exp_n:1,  exp_first:0};
        vt[8]  = '{x0:317,  y0:100,  w:10,   h:2,    color:24'h0F0F0F, rdy:1, exp_err:0, exp_n:6,  exp_first:32317};
        vt[9]  = '{x0:0,    y0:238,  w:2,    h:4,    color:24'hC0FFEE, rdy:0, exp_err:0, exp_n:4,  exp_first:76160};
        vt[10] = '{x0:1023, y0:1023, w:1023, h:1023, color:24'h777777, rdy:0, exp_err:1, exp_n:0,  exp_first:0};
        vt[11] = '{x0:300,  y0:0,    w:1023, h:1,    color:24'h123ABC, rdy:0, exp_err:0, exp_n:20, exp_first:300};

        n_rst = 1'b1;
        start = 1'b0;
        x0 = '0; y0 = '0; width = '0; height = '0; color = '0;
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_wr_valid", 32'(wr_valid), 32'd0);
        chk("reset_wr_addr", wr_addr, 32'd0);
        chk("reset_wr_data", wr_data, 32'd0);

        for (int i = 0; i < 12; i++) run_cmd(vt[i], 1'b0);

        // second start during FILL must be ignored
        vb = '{x0:0, y0:0, w:4, h:3, color:24'hFF00FF, rdy:1, exp_err:0, exp_n:12, exp_first:0};
        run_cmd(vb, 1'b1);

        reset_mid_fill();

        // engine still usable after the abandoned command
        run_cmd(vt[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
